// File: rtl/cu_pipe.sv
// cu_pipe: RV32I control-word decode carried through NSTAGES pipeline stages with load-use bubbles, flush, freeze and perf counters
module cu_pipe #(
  parameter int NSTAGES = 3,
  parameter int CNT_W   = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [31:0]          instr_in,
  input  logic                 stall,
  input  logic                 chng2nop,
  output logic [NSTAGES*11-1:0] cw_out,
  output logic [NSTAGES*5-1:0]  rd_out,
  output logic                 illegal_ex,
  output logic                 hazard_stall,
  output logic [CNT_W-1:0]     bubble_cnt,
  output logic [CNT_W-1:0]     flush_cnt
);
  localparam logic [10:0] CW_R     = 11'h201;
  localparam logic [10:0] CW_I     = 11'h411;
  localparam logic [10:0] CW_LOAD  = 11'h01B;
  localparam logic [10:0] CW_STORE = 11'h014;
  localparam logic [10:0] CW_BR    = 11'h620;
  localparam logic [10:0] CW_JAL   = 11'h1D1;
  localparam logic [10:0] CW_JALR  = 11'h0D1;
  localparam logic [10:0] CW_LUI   = 11'h011;
  localparam logic [10:0] CW_AUIPC = 11'h111;
  logic [NSTAGES*11-1:0] cw_q, cw_d;
  logic [NSTAGES*5-1:0]  rd_q, rd_d;
  logic                  ill_q, ill_d;
  logic [CNT_W-1:0]      bub_q, bub_d, fl_q, fl_d;
  logic [10:0]           dec_cw;
  logic [4:0]            dec_rd;
  logic                  dec_ill, use_rs1, use_rs2, load_use, insert_nop;
  // Opcode decode into control word, illegal flag and which source registers are read
  always_comb begin
    dec_cw  = '0;
    dec_ill = 1'b0;
    use_rs1 = 1'b0;
    use_rs2 = 1'b0;
    case (instr_in[6:0])
      7'b0110011: begin dec_cw = CW_R;     use_rs1 = 1'b1; use_rs2 = 1'b1; end
      7'b0010011: begin dec_cw = CW_I;     use_rs1 = 1'b1; end
      7'b0000011: begin dec_cw = CW_LOAD;  use_rs1 = 1'b1; end
      7'b0100011: begin dec_cw = CW_STORE; use_rs1 = 1'b1; use_rs2 = 1'b1; end
      7'b1100011: begin dec_cw = CW_BR;    use_rs1 = 1'b1; use_rs2 = 1'b1; end
      7'b1101111: dec_cw = CW_JAL;
      7'b1100111: begin dec_cw = CW_JALR;  use_rs1 = 1'b1; end
      7'b0110111: dec_cw = CW_LUI;
      7'b0010111: dec_cw = CW_AUIPC;
      default:    dec_ill = 1'b1;
    endcase
  end
  assign dec_rd = dec_cw[0] ? instr_in[11:7] : 5'd0;
  // A load in EX whose destination is read by the instruction in ID forces one bubble
  assign load_use = cw_q[1] && rd_q[4:0] != 5'd0 &&
                    ((use_rs1 && instr_in[19:15] == rd_q[4:0]) ||
                     (use_rs2 && instr_in[24:20] == rd_q[4:0]));
  assign hazard_stall = load_use && !stall && !chng2nop;
  assign insert_nop   = chng2nop || load_use;
  assign cw_d  = stall ? cw_q  : {cw_q[NSTAGES*11-12:0], insert_nop ? 11'd0 : dec_cw};
  assign rd_d  = stall ? rd_q  : {rd_q[NSTAGES*5-6:0], insert_nop ? 5'd0 : dec_rd};
  assign ill_d = stall ? ill_q : !insert_nop && dec_ill;
  assign bub_d = (hazard_stall && bub_q != '1) ? bub_q + CNT_W'(1) : bub_q;
  assign fl_d  = (!stall && chng2nop && fl_q != '1) ? fl_q + CNT_W'(1) : fl_q;
  // Stage registers and saturating counters, cleared immediately on reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cw_q  <= '0;
      rd_q  <= '0;
      ill_q <= 1'b0;
      bub_q <= '0;
      fl_q  <= '0;
    end else begin
      cw_q  <= cw_d;
      rd_q  <= rd_d;
      ill_q <= ill_d;
      bub_q <= bub_d;
      fl_q  <= fl_d;
    end
  end
  assign cw_out     = cw_q;
  assign rd_out     = rd_q;
  assign illegal_ex = ill_q;
  assign bubble_cnt = bub_q;
  assign flush_cnt  = fl_q;
endmodule

// File: tb/tb_cu_pipe.sv
// tb_cu_pipe: randomized and directed checks of cu_pipe against a stage-list reference model
module tb_cu_pipe;
  localparam int N = 3;
  localparam logic [10:0] RW = 11'h001, MR = 11'h002, MW = 11'h004, M2R = 11'h008, IMM = 11'h010;
  localparam logic [10:0] BR = 11'h020, JMP = 11'h040, LNK = 11'h080, PCB = 11'h100;
  localparam logic [10:0] A_R = 11'h200, A_I = 11'h400, A_B = 11'h600;
  localparam logic [31:0] ADD4 = 32'h00218233, LW5 = 32'h0000A283, ADD6 = 32'h00228333;
  localparam logic [31:0] JAL4 = 32'h0000026F, BEQ = 32'h00000063, NOP = 32'h00000013;
  logic clk = 1'b0, rst, stall, chng2nop;
  logic [31:0] instr;
  logic [N*11-1:0] cw_a, cw_b;
  logic [N*5-1:0] rd_a, rd_b;
  logic ill_a, ill_b, hz_a, hz_b;
  logic [15:0] bc_a, fc_a;
  logic [1:0] bc_b, fc_b;
  logic [10:0] mcw [1:N];
  logic [4:0] mrd [1:N];
  logic mill, last_hs, last_hs_b, last_hs_exp;
  int mbub, mfl, checks, failures;

  cu_pipe #(.NSTAGES(N), .CNT_W(16)) dut (.clk(clk), .rst(rst), .instr_in(instr), .stall(stall),
    .chng2nop(chng2nop), .cw_out(cw_a), .rd_out(rd_a), .illegal_ex(ill_a), .hazard_stall(hz_a),
    .bubble_cnt(bc_a), .flush_cnt(fc_a));
  cu_pipe #(.NSTAGES(N), .CNT_W(2)) dut_s (.clk(clk), .rst(rst), .instr_in(instr), .stall(stall),
    .chng2nop(chng2nop), .cw_out(cw_b), .rd_out(rd_b), .illegal_ex(ill_b), .hazard_stall(hz_b),
    .bubble_cnt(bc_b), .flush_cnt(fc_b));

  always #5 clk = ~clk;

  function automatic int sat(input int v, input int w);
    return (v > (1 << w) - 1) ? (1 << w) - 1 : v;
  endfunction

  function automatic logic [31:0] mk(input logic [6:0] op, input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2);
    return {7'd0, rs2, rs1, 3'd0, rd, op};
  endfunction

  function automatic void mdec(input logic [31:0] i, output logic [10:0] cw, output logic [4:0] rd,
                               output logic ill, output logic u1, output logic u2);
    cw = '0; ill = 1'b0; u1 = 1'b0; u2 = 1'b0;
    case (i[6:0])
      7'h33: begin cw = RW | A_R; u1 = 1'b1; u2 = 1'b1; end
      7'h13: begin cw = RW | IMM | A_I; u1 = 1'b1; end
      7'h03: begin cw = RW | MR | M2R | IMM; u1 = 1'b1; end
      7'h23: begin cw = MW | IMM; u1 = 1'b1; u2 = 1'b1; end
      7'h63: begin cw = BR | A_B; u1 = 1'b1; u2 = 1'b1; end
      7'h6F: cw = RW | JMP | LNK | PCB | IMM;
      7'h67: begin cw = RW | JMP | LNK | IMM; u1 = 1'b1; end
      7'h37: cw = RW | IMM;
      7'h17: cw = RW | PCB | IMM;
      default: ill = 1'b1;
    endcase
    rd = (cw & RW) != 0 ? i[11:7] : 5'd0;
  endfunction

  task automatic mreset();
    for (int k = 1; k <= N; k++) begin mcw[k] = '0; mrd[k] = '0; end
    mill = 1'b0; mbub = 0; mfl = 0;
  endtask

  // applies inputs for one cycle, samples hazard_stall before the edge, advances the model
  task automatic apply(input logic [31:0] i, input logic s, input logic f);
    logic [10:0] c; logic [4:0] r; logic il, u1, u2, hz;
    instr = i; stall = s; chng2nop = f;
    #1;
    mdec(instr, c, r, il, u1, u2);
    hz = (mcw[1] & MR) != 0 && mrd[1] != 0 &&
         ((u1 && instr[19:15] == mrd[1]) || (u2 && instr[24:20] == mrd[1]));
    last_hs_exp = hz && !s && !f;
    last_hs = hz_a; last_hs_b = hz_b;
    @(posedge clk);
    if (!s) begin
      for (int k = N; k > 1; k--) begin mcw[k] = mcw[k-1]; mrd[k] = mrd[k-1]; end
      if (f || hz) begin
        mcw[1] = '0; mrd[1] = '0; mill = 1'b0;
        if (f) mfl++; else mbub++;
      end else begin
        mcw[1] = c; mrd[1] = r; mill = il;
      end
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    #2 rst = 1'b1;
    mreset();
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    apply(LW5, 1'b0, 1'b0);
    apply(ADD6, 1'b0, 1'b0);
    apply(ADD6, 1'b0, 1'b0);
    apply(32'h0000007F, 1'b0, 1'b1);
    apply(32'h0000007F, 1'b0, 1'b0);
    checks++;
    if (cw_a == 0 || bc_a != 16'd1 || fc_a != 16'd1 || !ill_a) begin
      failures++; $display("FAIL reset_precond cw=%h bub=%0d fl=%0d ill=%b need nonzero state", cw_a, bc_a, fc_a, ill_a);
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({cw_a, rd_a, ill_a, bc_a, fc_a, hz_a} !== '0 || {cw_b, rd_b, ill_b, bc_b, fc_b} !== '0) begin
      failures++; $display("FAIL reset_async cw=%h rd=%h ill=%b bub=%0d fl=%0d hz=%b expected all 0", cw_a, rd_a, ill_a, bc_a, fc_a, hz_a);
    end
    mreset();
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_shift();
    do_reset();
    apply(ADD4, 1'b0, 1'b0);
    checks++;
    if (cw_a[10:0] !== 11'h201 || rd_a[4:0] !== 5'd4) begin
      failures++; $display("FAIL shift_s1 cw=%h rd=%0d expected 201/4", cw_a[10:0], rd_a[4:0]);
    end
    apply(NOP, 1'b0, 1'b0);
    checks++;
    if (cw_a[21:11] !== 11'h201 || rd_a[9:5] !== 5'd4 || cw_a[10:0] !== 11'h411 || rd_a[4:0] !== 5'd0) begin
      failures++; $display("FAIL shift_s2 cw=%h rd=%0d s1=%h expected 201/4 s1=411", cw_a[21:11], rd_a[9:5], cw_a[10:0]);
    end
    apply(NOP, 1'b0, 1'b0);
    checks++;
    if (cw_a[32:22] !== 11'h201 || rd_a[14:10] !== 5'd4) begin
      failures++; $display("FAIL shift_s3 cw=%h rd=%0d expected 201/4", cw_a[32:22], rd_a[14:10]);
    end
  endtask

  task automatic test_load_use();
    do_reset();
    apply(LW5, 1'b0, 1'b0);
    apply(ADD6, 1'b0, 1'b0);
    checks++;
    if (last_hs !== 1'b1 || cw_a[10:0] !== 11'h0 || cw_a[21:11] !== 11'h01B || bc_a !== 16'd1) begin
      failures++; $display("FAIL load_use_bubble hs=%b s1=%h s2=%h bub=%0d expected 1/0/01b/1", last_hs, cw_a[10:0], cw_a[21:11], bc_a);
    end
    apply(ADD6, 1'b0, 1'b0);
    checks++;
    if (last_hs !== 1'b0 || cw_a[10:0] !== 11'h201 || rd_a[4:0] !== 5'd6 || bc_a !== 16'd1) begin
      failures++; $display("FAIL load_use_resume hs=%b s1=%h rd=%0d bub=%0d expected 0/201/6/1", last_hs, cw_a[10:0], rd_a[4:0], bc_a);
    end
  endtask

  task automatic test_flush();
    do_reset();
    apply(JAL4, 1'b0, 1'b0);
    apply(BEQ, 1'b0, 1'b1);
    checks++;
    if (cw_a[10:0] !== 11'h0 || rd_a[4:0] !== 5'd0 || fc_a !== 16'd1 || cw_a[21:11] !== 11'h1D1 || rd_a[9:5] !== 5'd4) begin
      failures++; $display("FAIL flush s1=%h fl=%0d s2=%h rd2=%0d expected 0/1/1d1/4", cw_a[10:0], fc_a, cw_a[21:11], rd_a[9:5]);
    end
    apply(LW5, 1'b0, 1'b0);
    apply(ADD6, 1'b0, 1'b1);
    checks++;
    if (last_hs !== 1'b0 || bc_a !== 16'd0 || fc_a !== 16'd2 || cw_a[10:0] !== 11'h0) begin
      failures++; $display("FAIL flush_over_hazard hs=%b bub=%0d fl=%0d s1=%h expected 0/0/2/0", last_hs, bc_a, fc_a, cw_a[10:0]);
    end
  endtask

  task automatic test_freeze();
    logic [N*11-1:0] scw; logic [N*5-1:0] srd;
    do_reset();
    apply(ADD4, 1'b0, 1'b0);
    apply(LW5, 1'b0, 1'b0);
    scw = cw_a; srd = rd_a;
    for (int i = 0; i < 3; i++) begin
      apply(ADD6, 1'b1, i == 1);
      checks++;
      if (last_hs !== 1'b0 || cw_a !== scw || rd_a !== srd || bc_a !== 16'd0 || fc_a !== 16'd0) begin
        failures++; $display("FAIL freeze_%0d hs=%b cw=%h rd=%h bub=%0d fl=%0d expected hold cw=%h", i, last_hs, cw_a, rd_a, bc_a, fc_a, scw);
      end
    end
    apply(ADD6, 1'b0, 1'b0);
    checks++;
    if (last_hs !== 1'b1 || bc_a !== 16'd1 || cw_a[10:0] !== 11'h0) begin
      failures++; $display("FAIL freeze_release hs=%b bub=%0d s1=%h expected 1/1/0", last_hs, bc_a, cw_a[10:0]);
    end
  endtask

  task automatic test_saturation();
    do_reset();
    for (int i = 0; i < 5; i++) begin
      apply(LW5, 1'b0, 1'b0);
      apply(ADD6, 1'b0, 1'b0);
      apply(ADD6, 1'b0, 1'b0);
    end
    checks++;
    if (bc_b !== 2'd3 || bc_a !== 16'd5) begin
      failures++; $display("FAIL saturation bub2=%0d bub16=%0d expected 3/5", bc_b, bc_a);
    end
    apply(32'h0000007F, 1'b0, 1'b0);
    checks++;
    if (ill_a !== 1'b1 || ill_b !== 1'b1 || cw_a[10:0] !== 11'h0 || rd_a[4:0] !== 5'd0) begin
      failures++; $display("FAIL illegal_7f ill=%b cw=%h rd=%0d expected 1/0/0", ill_a, cw_a[10:0], rd_a[4:0]);
    end
    apply(32'h00000000, 1'b0, 1'b0);
    checks++;
    if (ill_a !== 1'b1 || cw_a[10:0] !== 11'h0) begin
      failures++; $display("FAIL illegal_zero ill=%b cw=%h expected 1/0", ill_a, cw_a[10:0]);
    end
  endtask

  task automatic test_random();
    logic [6:0] ops [0:9];
    ops = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h6F, 7'h67, 7'h37, 7'h17, 7'h7F};
    do_reset();
    for (int n = 0; n < 400; n++) begin
      apply(mk(ops[$urandom_range(0, 9)], 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3))),
            $urandom_range(0, 7) == 0, $urandom_range(0, 7) == 0);
      checks++;
      if (last_hs !== last_hs_exp || last_hs_b !== last_hs_exp) begin
        failures++; $display("FAIL rnd_hazard n=%0d got %b/%b expected %b", n, last_hs, last_hs_b, last_hs_exp);
      end
      checks++;
      if (cw_a !== {mcw[3], mcw[2], mcw[1]} || rd_a !== {mrd[3], mrd[2], mrd[1]} || ill_a !== mill) begin
        failures++; $display("FAIL rnd_stages n=%0d cw=%h rd=%h ill=%b expected %h %h %b", n, cw_a, rd_a, ill_a,
                             {mcw[3], mcw[2], mcw[1]}, {mrd[3], mrd[2], mrd[1]}, mill);
      end
      checks++;
      if (cw_b !== {mcw[3], mcw[2], mcw[1]} || rd_b !== {mrd[3], mrd[2], mrd[1]} || ill_b !== mill) begin
        failures++; $display("FAIL rnd_stages_b n=%0d cw=%h rd=%h expected %h %h", n, cw_b, rd_b,
                             {mcw[3], mcw[2], mcw[1]}, {mrd[3], mrd[2], mrd[1]});
      end
      checks++;
      if (bc_a !== 16'(sat(mbub, 16)) || fc_a !== 16'(sat(mfl, 16)) || bc_b !== 2'(sat(mbub, 2)) || fc_b !== 2'(sat(mfl, 2))) begin
        failures++; $display("FAIL rnd_counters n=%0d bub=%0d fl=%0d bub2=%0d fl2=%0d expected %0d %0d %0d %0d", n, bc_a, fc_a, bc_b, fc_b,
                             sat(mbub, 16), sat(mfl, 16), sat(mbub, 2), sat(mfl, 2));
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    checks = 0; failures = 0;
    rst = 1'b1; instr = NOP; stall = 1'b0; chng2nop = 1'b0;
    mreset();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    test_reset();
    test_shift();
    test_load_use();
    test_flush();
    test_freeze();
    test_saturation();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/cu_pipe.md
# cu_pipe

Parametrised pipelined control unit for the RV32I core. It decodes the instruction in ID into a control word and carries that word, plus its destination register, through `NSTAGES` registered pipeline stages. It has built-in load-use hazard detection with bubble insertion, flush-to-NOP, and global freeze. Saturating bubble and flush counters are included for performance monitoring. It replaces the fixed-depth `cu` between fetch/ID and the datapath.

## Interface
- `NSTAGES`, 3, number of registered stages after ID (stage 1 = EX … stage NSTAGES = WB); legal 2..8
- `CNT_W`, 16, width of performance counters
- `clk`  in  1  clock, rising edge
- `rst`  in  1  asynchronous, active-high reset
- `instr_in`  in  32  instruction currently in ID
- `stall`  in  1  global freeze (memory wait): all stages hold
- `chng2nop`  in  1  flush: the instruction in ID is replaced by NOP on entry to stage 1
- `cw_out`  out  NSTAGES*11  stage k control word at bits [11k-1 : 11(k-1)]
- `rd_out`  out  NSTAGES*5  stage k destination register, same packing at width 5
- `illegal_ex`  out  1  stage-1 instruction had an undecodable opcode
- `hazard_stall`  out  1  combinational; ID/IF must hold this cycle
- `bubble_cnt`  out  CNT_W  hazard bubbles inserted, saturating
- `flush_cnt`  out  CNT_W  flush cycles, saturating

## Operation
- Control word bits:
  - [0] reg_write
  - [1] mem_read
  - [2] mem_write
  - [3] mem_to_reg
  - [4] alu_src_imm
  - [5] branch
  - [6] jump
  - [7] link
  - [8] pc_base
  - [10:9] alu_op: 00 add, 01 R-funct, 10 I-funct, 11 branch compare
- Decode by opcode[6:0]:
  - 0110011 R: rw, alu_op 01
  - 0010011 I-ALU: rw, imm, 10
  - 0000011 load: rw, mem_read, mem_to_reg, imm, 00
  - 0100011 store: mem_write, imm, 00
  - 1100011 branch: branch, 11
  - 1101111 jal: rw, jump, link, pc_base, imm
  - 1100111 jalr: rw, jump, link, imm
  - 0110111 lui: rw, imm
  - 0010111 auipc: rw, pc_base, imm
  - Any other opcode: all zeros (NOP) and illegal flag set.
- rd field is instr_in[11:7] for any word with reg_write, else 0.
- rs1 is used by R, I-ALU, load, store, branch and jalr. rs2 is used by R, store and branch.
- Load-use hazard: stage-1 mem_read=1, stage-1 rd≠0, and rd equals a used rs of instr_in.
- Each cycle, priority is rst > stall > chng2nop > hazard > normal:
  - stall: every stage register holds. hazard_stall=0. Counters hold.
  - chng2nop: stage 1 loads NOP (cw=0, rd=0, illegal=0). Stages 2..N shift. flush_cnt +1. hazard_stall=0.
  - hazard: stage 1 loads NOP. Stages 2..N shift. hazard_stall=1. bubble_cnt +1.
  - normal: stage 1 loads decoded word, rd and illegal flag. Stage k loads stage k-1.
- Counters saturate at 2^CNT_W−1 and never wrap.
- A NOP encoding (all-zero instruction) decodes as illegal. Upstream injects 0x00000013 for true NOP.

## Timing
- Reset, asynchronous: all cw_out, rd_out, illegal_ex, bubble_cnt and flush_cnt are 0 immediately, held until first clk edge after deassert.
- Decode and hazard_stall are combinational from instr_in and stage-1 registers, within the same cycle.
- An instruction accepted at edge T appears on stage k at edge T+k−1. Its latency to WB is NSTAGES cycles.
- A hazard bubble lasts exactly one cycle. The load reaches stage 2, the hazard clears, and the consumer enters stage 1 on the next edge.
- stall combined with any other condition: freeze wins. Hazard is re-evaluated after stall drops.
- chng2nop combined with a hazard: flush wins. bubble_cnt does not increment.
- Reset asserted mid-operation clears all in-flight control words at once. No partial state survives.

## Test plan
- Reset:
  - Stimulus: assert rst mid-stream.
  - Required: all outputs are 0 asynchronously, before the next edge.
- Pipeline shift (NSTAGES=3):
  - Stimulus: `add x4,x3,x2` (0x00218233).
  - Required: cw=0x201 and rd=4 on stage 1, then stage 2, then stage 3, on three consecutive cycles.
- Load-use:
  - Stimulus: `lw x5,0(x1)` (0x0000A283) then `add x6,x5,x2` (0x00228333).
  - Required: hazard_stall=1 for one cycle; stage 1 = NOP; bubble_cnt=1; add enters stage 1 the following cycle.
- Flush:
  - Stimulus: `jal x4` then chng2nop=1 with `beq` in ID.
  - Required: stage 1 = 0; flush_cnt=1; jal cw=0x1D1 on stage 2.
- Freeze:
  - Stimulus: stall=1 for 3 cycles during a load-use pair.
  - Required: all stages unchanged; hazard_stall=0; bubble increments only after stall drops.
- Saturation and illegal:
  - Stimulus: CNT_W=2 with 5 hazards; then opcode 0x7F.
  - Required: bubble_cnt=3; illegal_ex=1 with cw=0.
